// File: rtl/serial_adder.sv
// serial_adder: bit-serial LSB-first unsigned adder, one bit per clock,
// publishing {cout, sum} with a single-cycle done pulse.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t           r_state, w_next;
  logic [WIDTH-1:0] r_sa, r_sb, r_res, w_res;
  logic [CW-1:0]    r_cnt;
  logic             r_carry, w_hs, w_hc, w_s, w_c, w_last;
  assign w_hs   = r_sa[0] ^ r_sb[0];
  assign w_hc   = r_sa[0] & r_sb[0];
  assign w_s    = w_hs ^ r_carry;
  assign w_c    = w_hc | (w_hs & r_carry);
  assign w_res  = {w_s, r_res[WIDTH-1:1]};
  assign w_last = r_cnt == CW'(WIDTH - 1);
  assign busy   = r_state != IDLE;
  assign done   = r_state == DONE;
  always_comb begin
    w_next = IDLE;
    w_next = (r_state == IDLE) ? (start ? RUN : IDLE) :
             (r_state == RUN)  ? (w_last ? DONE : RUN) : IDLE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end
  // sum/cout are only published on the final RUN edge; r_res stays internal
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sa    <= '0;
      r_sb    <= '0;
      r_res   <= '0;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      sum     <= '0;
      cout    <= 1'b0;
    end else if (r_state == IDLE && start) begin
      r_sa    <= a;
      r_sb    <= b;
      r_res   <= '0;
      r_cnt   <= '0;
      r_carry <= 1'b0;
    end else if (r_state == RUN) begin
      r_sa    <= {1'b0, r_sa[WIDTH-1:1]};
      r_sb    <= {1'b0, r_sb[WIDTH-1:1]};
      r_res   <= w_res;
      r_carry <= w_c;
      r_cnt   <= r_cnt + 1'b1;
      if (w_last) begin
        sum  <= w_res;
        cout <= w_c;
      end
    end
  end
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed and random checks of the 8-bit serial adder.
module tb_serial_adder;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] a = '0, b = '0;
  logic       busy, done, cout;
  logic [7:0] sum;
  int         checks = 0;
  int         failures = 0;
  int         pulses, last_t, prev_done;
  logic [8:0] ref9;

  serial_adder #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .sum(sum), .cout(cout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // accept at E0, verify busy/hold during RUN, done+result at E8, idle at E9
  task automatic run_add(input string tag, input logic [7:0] ta, input logic [7:0] tb_,
                         input logic [7:0] es, input logic ec);
    logic [8:0] held;
    @(negedge clk);
    a = ta; b = tb_; start = 1'b1;
    held = {cout, sum};
    @(posedge clk); #1;
    start = 1'b0; a = 8'hxx; b = 8'hxx;
    check({tag, " busy@E0"}, {31'd0, busy}, 32'd1);
    check({tag, " done@E0"}, {31'd0, done}, 32'd0);
    for (int i = 1; i < 8; i++) begin
      @(posedge clk); #1;
      check({tag, " run done/busy/hold"}, {22'd0, done, busy, cout, sum}, {22'd0, 1'b0, 1'b1, held});
    end
    @(posedge clk); #1;
    check({tag, " done@E8"}, {31'd0, done}, 32'd1);
    check({tag, " result@E8"}, {23'd0, cout, sum}, {23'd0, ec, es});
    @(posedge clk); #1;
    check({tag, " done/busy@E9"}, {30'd0, done, busy}, 32'd0);
  endtask

  initial begin
    #1;
    check("async reset outputs", {21'd0, busy, done, cout, sum}, 32'd0);
    // start and rst together: rst wins, nothing loads
    start = 1'b1; a = 8'h11; b = 8'h22;
    @(posedge clk); #1;
    check("rst beats start", {31'd0, busy}, 32'd0);
    @(negedge clk);
    start = 1'b0; rst = 1'b0;
    @(posedge clk); #1;
    check("idle after reset", {30'd0, busy, done}, 32'd0);

    run_add("5A+3C", 8'h5A, 8'h3C, 8'h96, 1'b0);
    run_add("FF+01", 8'hFF, 8'h01, 8'h00, 1'b1);
    run_add("00+00", 8'h00, 8'h00, 8'h00, 1'b0);
    run_add("80+7F", 8'h80, 8'h7F, 8'hFF, 1'b0);
    run_add("FF+FF", 8'hFF, 8'hFF, 8'hFE, 1'b1);

    // second start at E3 must be ignored
    @(negedge clk);
    a = 8'h10; b = 8'h20; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    a = 8'hFF; b = 8'hFF; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    pulses = 0;
    for (int i = 4; i <= 14; i++) begin
      @(posedge clk); #1;
      if (done) begin
        pulses++;
        check("ignored start result", {23'd0, cout, sum}, 32'h030);
      end
    end
    check("ignored start one done", pulses, 1);
    check("ignored start idle", {31'd0, busy}, 32'd0);

    // async reset mid-RUN after E4 of 80+80
    @(negedge clk);
    a = 8'h80; b = 8'h80; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("mid-run rst outputs", {21'd0, busy, done, cout, sum}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run_add("01+02 after rst", 8'h01, 8'h02, 8'h03, 1'b0);

    // start held high: done every 10 cycles
    @(negedge clk);
    a = 8'hAA; b = 8'h55; start = 1'b1;
    pulses = 0; last_t = -1; prev_done = 0;
    for (int t = 0; t < 40; t++) begin
      @(posedge clk); #1;
      if (done) begin
        check("stream result", {23'd0, cout, sum}, 32'h0FF);
        check("stream no double done", prev_done, 0);
        if (last_t >= 0) check("stream period", t - last_t, 10);
        last_t = t;
        pulses++;
      end
      prev_done = done;
    end
    check("stream pulse count", pulses, 4);
    @(negedge clk);
    start = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    check("stream drained", {31'd0, busy}, 32'd0);

    // random operands against a + b
    for (int k = 0; k < 40; k++) begin
      logic [7:0] ra, rb;
      ra = 8'($urandom);
      rb = 8'($urandom);
      ref9 = {1'b0, ra} + {1'b0, rb};
      run_add("random", ra, rb, ref9[7:0], ref9[8]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog timeout");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end
endmodule
